ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter NBITS, default 32, the operand width and the width of HI and LO.
REQ-002 SHALL have ports:
  i_clk  input  1  single clock; all state updates on its rising edge.
  i_rst_n  input  1  reset; asynchronous assertion, active-low.
  i_start  input  1  request to start the operation in i_op.
  i_op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
  i_reg1  input  NBITS  rs operand: multiplicand or dividend; also the MTHI/MTLO data.
  i_reg2  input  NBITS  rt operand: multiplier or divisor.
  i_wr_hi  input  1  MTHI: write i_reg1 into HI.
  i_wr_lo  input  1  MTLO: write i_reg1 into LO.
  i_flush  input  1  abort any operation in progress.
  o_busy  output  1  operation in progress; the pipeline stalls on MFHI/MFLO while high.
  o_done  output  1  one-cycle pulse: result written.
  o_div_by_zero  output  1  pulses with o_done when a DIV or DIVU had i_reg2 == 0.
  o_hi  output  NBITS  architectural HI register.
  o_lo  output  NBITS  architectural LO register.

Function
REQ-003 SHALL implement the FSM states IDLE, RUN, FIX and DONE.
REQ-004 SHALL accept i_start only in IDLE; i_start in any other state is ignored.
REQ-005 On acceptance, SHALL latch i_op, i_reg1 and i_reg2, clear the iteration counter and enter RUN.
REQ-006 Signed ops SHALL convert both operands to magnitudes at latch and record the result signs.
REQ-007 RUN SHALL process exactly one operand bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-008 RUN SHALL last NBITS cycles, with a counter of ceil(log2(NBITS)) bits, then go to FIX.
REQ-009 FIX SHALL apply the sign correction, write HI/LO and go to DONE.
REQ-010 DONE SHALL assert o_done for one cycle and then go to IDLE.
REQ-011 o_done SHALL be high in the cycle after the (NBITS+1)th rising edge following the edge that sampled i_start.
REQ-012 o_busy SHALL be high in RUN and FIX only.
REQ-013 Multiply SHALL write HI = upper NBITS and LO = lower NBITS of the 2*NBITS-bit product; MULT is two's-complement.
REQ-014 Divide SHALL write LO = quotient and HI = remainder.
REQ-015 DIV SHALL truncate the quotient toward zero; the remainder takes the sign of the dividend.
REQ-016 DIV of the most negative value by -1 SHALL write LO = 0x80000000 and HI = 0.
REQ-017 Divide with i_reg2 == 0 SHALL go from the sampling edge directly to DONE, leave HI/LO unchanged and pulse o_div_by_zero with o_done.
REQ-018 i_flush SHALL force IDLE on the next edge, discarding partial results; HI/LO are unchanged and no o_done is issued.
REQ-019 i_flush SHALL take priority over i_start in the same cycle.
REQ-020 i_wr_hi and i_wr_lo SHALL take effect only in IDLE with i_start low.
REQ-021 If i_start is high in the same IDLE cycle, the start SHALL win and the writes SHALL be dropped.
REQ-022 i_wr_hi and i_wr_lo SHALL both take effect when asserted together.
REQ-023 o_hi and o_lo SHALL be driven directly from registers.

Reset
REQ-024 While i_rst_n = 0, SHALL force the FSM to IDLE.
REQ-025 While i_rst_n = 0, SHALL hold o_busy, o_done and o_div_by_zero at 0.
REQ-026 While i_rst_n = 0, SHALL hold o_hi and o_lo at 0, and the counter and operand registers at 0.
REQ-027 Reset during RUN or FIX SHALL abandon the operation with no o_done.

Structure
REQ-028 The op encodings (MULTU, MULT, DIVU, DIV) and the FSM state encoding SHALL live in shared package ex_muldiv_pkg.
REQ-029 SHALL be a single module with no sub-modules; the sign-conversion helpers are package functions.

Verification
REQ-030 MULTU with i_reg1 = 0xFFFFFFFF, i_reg2 = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001, o_done in the cycle after the 33rd edge after start.
REQ-031 MULT with -3 and 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
REQ-032 DIV with -7 and 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIV with 0x80000000 and -1 -> LO = 0x80000000, HI = 0.
REQ-033 DIVU with 10 and 0 -> o_done and o_div_by_zero high one cycle after start; HI/LO keep their prior values; o_busy never high.
REQ-034 MULTU started, then i_flush in RUN cycle 10 -> IDLE next cycle, o_busy low, no o_done, HI/LO unchanged.
REQ-035 i_start with i_wr_lo in the same IDLE cycle -> the multiply runs and the MTLO write is dropped.
REQ-036 i_rst_n low mid-RUN -> all outputs 0 immediately; a start after release runs normally.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and sign helpers for the iterative multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned MAX_W = 128;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Two's-complement negate when neg is set; callers zero-extend and truncate.
    function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one operand bit per cycle, sign fix-up
// on magnitudes, MTHI/MTLO writes while idle.
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [NBITS-1:0] i_reg1,
    input  logic [NBITS-1:0] i_reg2,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [NBITS-1:0] o_hi,
    output logic [NBITS-1:0] o_lo
);

    localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned PW = 2 * NBITS;

    state_e           state, state_next;
    op_e              op_q;
    logic [NBITS-1:0] acc, shreg, opb;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r;

    logic             accept, start_dbz;
    logic             sa, sb;
    logic [NBITS-1:0] mag1, mag2;
    logic [NBITS:0]   mul_sum, div_shift;
    logic [NBITS+1:0] div_diff;
    logic [NBITS-1:0] acc_step, shreg_step, hi_res, lo_res;
    logic [PW-1:0]    prod;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next state; flush overrides everything, including a start in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        start_dbz  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    accept     = 1'b1;
                    start_dbz  = is_div_op(op_e'(i_op)) && (i_reg2 == '0);
                    state_next = start_dbz ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN:  if (cnt == CW'(NBITS - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (i_flush) begin
            state_next = ST_IDLE;
            accept     = 1'b0;
            start_dbz  = 1'b0;
        end
    end

    // Operand magnitudes, one iteration step, and sign-corrected results.
    always_comb begin
        sa   = is_signed_op(op_e'(i_op)) && i_reg1[NBITS-1];
        sb   = is_signed_op(op_e'(i_op)) && i_reg2[NBITS-1];
        mag1 = NBITS'(neg_if(MAX_W'(i_reg1), sa));
        mag2 = NBITS'(neg_if(MAX_W'(i_reg2), sb));

        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opb} : {(NBITS+1){1'b0}});
        div_shift = {acc, shreg[NBITS-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};

        if (is_div_op(op_q)) begin
            if (!div_diff[NBITS+1]) begin
                acc_step   = NBITS'(div_diff);
                shreg_step = {shreg[NBITS-2:0], 1'b1};
            end else begin
                acc_step   = NBITS'(div_shift);
                shreg_step = {shreg[NBITS-2:0], 1'b0};
            end
        end else begin
            acc_step   = mul_sum[NBITS:1];
            shreg_step = {mul_sum[0], shreg[NBITS-1:1]};
        end

        prod = PW'(neg_if(MAX_W'({acc, shreg}), sign_q));
        if (is_div_op(op_q)) begin
            lo_res = NBITS'(neg_if(MAX_W'(shreg), sign_q));
            hi_res = NBITS'(neg_if(MAX_W'(acc), sign_r));
        end else begin
            hi_res = prod[PW-1:NBITS];
            lo_res = prod[NBITS-1:0];
        end
    end

    // Datapath: multiplier/dividend shifts through shreg, partial sum or remainder in acc.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q          <= OP_MULTU;
            acc           <= '0;
            shreg         <= '0;
            opb           <= '0;
            cnt           <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            o_hi          <= '0;
            o_lo          <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= op_e'(i_op);
                acc    <= '0;
                cnt    <= '0;
                sign_q <= sa ^ sb;
                sign_r <= sa;
                if (is_div_op(op_e'(i_op))) begin
                    shreg <= mag1;
                    opb   <= mag2;
                end else begin
                    shreg <= mag2;
                    opb   <= mag1;
                end
            end else if (state == ST_RUN && !i_flush) begin
                acc   <= acc_step;
                shreg <= shreg_step;
                cnt   <= cnt + CW'(1);
            end

            if (state == ST_FIX && !i_flush) begin
                o_hi <= hi_res;
                o_lo <= lo_res;
            end else if (state == ST_IDLE && !i_start) begin
                if (i_wr_hi) o_hi <= i_reg1;
                if (i_wr_lo) o_lo <= i_reg1;
            end

            o_busy        <= (state_next == ST_RUN) || (state_next == ST_FIX);
            o_done        <= (state_next == ST_DONE);
            o_div_by_zero <= start_dbz;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: constant vector table, hand-written
// corner sequences, and random operations checked against an arithmetic model.
module tb_ex_muldiv_unit;

    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, flush, wr_hi, wr_lo;
    logic [1:0]    op;
    logic [N-1:0]  r1, r2;
    logic          busy, done, dbz;
    logic [N-1:0]  hi, lo;

    int n_vec = 0;
    int n_bad = 0;
    logic [N-1:0] m_hi = '0;
    logic [N-1:0] m_lo = '0;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a, b, hi, lo;
        bit           dz;
    } vec_t;

    ex_muldiv_unit #(.NBITS(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_reg1(r1), .i_reg2(r2), .i_wr_hi(wr_hi), .i_wr_lo(wr_lo),
        .i_flush(flush), .o_busy(busy), .o_done(done),
        .o_div_by_zero(dbz), .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one operation from plain integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] eh, output logic [N-1:0] el, output bit dz);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = m_hi;
        el = m_lo;
        dz = 1'b0;
        case (o)
            2'b00: begin up = {32'b0, a} * {32'b0, b}; eh = up[63:32]; el = up[31:0]; end
            2'b01: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'b10: if (b == 0) dz = 1'b1; else begin el = a / b; eh = a % b; end
            default: if (b == 0) dz = 1'b1;
                     else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
        endcase
    endtask

    // Issue one op and check latency, busy profile, done pulse and results.
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eh, input logic [N-1:0] el, input bit edz,
                          input string tag);
        int n;
        bit seen, busy_ok;
        logic dz_at_done, busy_at_done;
        n = 0; seen = 0; busy_ok = 1; dz_at_done = 0; busy_at_done = 1;
        @(negedge clk);
        op = o; r1 = a; r2 = b; start = 1'b1;
        while (n < 60 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1; dz_at_done = dbz; busy_at_done = busy;
            end else if (busy !== (edz ? 1'b0 : 1'b1)) begin
                busy_ok = 0;
            end
        end
        check({tag, "_latency"}, 64'(n), edz ? 64'd1 : 64'd34);
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        check({tag, "_dbz"}, 64'(dz_at_done), 64'(edz));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    task automatic watch_no_done(input string tag);
        int seen;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check({tag, "_quiet"}, 64'(seen), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        vec_t vecs[13];
        logic [N-1:0] eh, el, a, b;
        logic [1:0] o;
        bit dz;
        int n;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[5]  = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7]  = '{2'b01, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[8]  = '{2'b10, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0};
        vecs[9]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[10] = '{2'b10, 32'd10,       32'd0,        32'h00000000, 32'h80000000, 1'b1};
        vecs[11] = '{2'b11, 32'h00000000, 32'd0,        32'h00000000, 32'h80000000, 1'b1};
        vecs[12] = '{2'b00, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0};

        rst_n = 1'b0; start = 0; flush = 0; wr_hi = 0; wr_lo = 0; op = 0; r1 = 0; r2 = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
                   $sformatf("vec%0d", i));

        // MTHI/MTLO together, then MTLO alone.
        @(negedge clk); r1 = 32'hA5A5_0001; wr_hi = 1; wr_lo = 1;
        @(negedge clk); wr_hi = 0; wr_lo = 0;
        check("mthi_both", 64'(hi), 64'h A5A5_0001);
        check("mtlo_both", 64'(lo), 64'h A5A5_0001);
        r1 = 32'h0000_BEEF; wr_lo = 1;
        @(negedge clk); wr_lo = 0;
        check("mtlo_only_lo", 64'(lo), 64'h0000_BEEF);
        check("mtlo_only_hi", 64'(hi), 64'h A5A5_0001);
        m_hi = 32'hA5A5_0001; m_lo = 32'h0000_BEEF;

        // Start and MTLO in the same cycle: the write is dropped.
        op = 2'b00; r1 = 32'd6; r2 = 32'd7; start = 1; wr_lo = 1;
        @(negedge clk); start = 0; wr_lo = 0;
        check("start_vs_mtlo_hold", 64'(lo), 64'(m_lo));
        wait_done(n);
        check("start_vs_mtlo_lat", 64'(n), 64'd33);
        check("start_vs_mtlo_hi", 64'(hi), 64'd0);
        check("start_vs_mtlo_lo", 64'(lo), 64'd42);
        m_hi = 0; m_lo = 42;

        // Flush in RUN cycle 10.
        @(negedge clk); op = 2'b00; r1 = 32'hDEAD_BEEF; r2 = 32'h1234_5678; start = 1;
        @(negedge clk); start = 0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1;
        @(negedge clk); flush = 0;
        check("flush_busy_after", 64'(busy), 64'd0);
        watch_no_done("flush");

        // Flush beats a simultaneous start.
        @(negedge clk); op = 2'b01; r1 = 32'd3; r2 = 32'd3; start = 1; flush = 1;
        @(negedge clk); start = 0; flush = 0;
        watch_no_done("flush_start");

        // A second start while busy is ignored.
        @(negedge clk); op = 2'b10; r1 = 32'd1000; r2 = 32'd10; start = 1;
        @(negedge clk); start = 0;
        repeat (4) @(negedge clk);
        op = 2'b00; r1 = 32'hFFFF; r2 = 32'hFFFF; start = 1;
        @(negedge clk); start = 0;
        wait_done(n);
        check("restart_ignored_lat", 64'(n), 64'd28);
        check("restart_ignored_lo", 64'(lo), 64'd100);
        check("restart_ignored_hi", 64'(hi), 64'd0);
        m_hi = 0; m_lo = 100;

        // Reset in the middle of RUN.
        @(negedge clk); op = 2'b01; r1 = 32'hFFFF_FF00; r2 = 32'd77; start = 1;
        @(negedge clk); start = 0;
        repeat (5) @(negedge clk);
        rst_n = 0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_dbz", 64'(dbz), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        m_hi = 0; m_lo = 0;
        @(negedge clk); rst_n = 1;
        model(2'b01, 32'hFFFFFFFD, 32'd5, eh, el, dz);
        run_op(2'b01, 32'hFFFFFFFD, 32'd5, eh, el, dz, "after_rst");

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            model(o, a, b, eh, el, dz);
            run_op(o, a, b, eh, el, dz, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
